// File: rtl/minmax_pkg.sv
// Shared constants and the left-wins select rule for the min/max reduction tree.
package minmax_pkg;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  // Operands are left-aligned into MAX_W bits so the sign bit is always the top bit.
  localparam int MAX_W = 64;

  function automatic logic minmax_sel(input logic [MAX_W-1:0] a,
                                      input logic [MAX_W-1:0] b,
                                      input logic             a_pres,
                                      input logic             b_pres,
                                      input logic             mode,
                                      input logic             sgn);
    logic [MAX_W-1:0] ka;
    logic [MAX_W-1:0] kb;
    ka = a;
    kb = b;
    if (!b_pres) return 1'b1;
    if (!a_pres) return 1'b0;
    if (sgn) begin
      ka[MAX_W-1] = ~ka[MAX_W-1];
      kb[MAX_W-1] = ~kb[MAX_W-1];
    end
    if (mode == MODE_MAX) return (ka >= kb);
    return (ka <= kb);
  endfunction

endpackage

// File: rtl/minmax_node.sv
// One registered 2:1 reduction node; the left input wins ties and carries mode/sign down.
module minmax_node
  import minmax_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a_val,
  input  logic [IDX_W-1:0] a_idx,
  input  logic             a_pres,
  input  logic             a_mode,
  input  logic             a_sgn,
  input  logic [WIDTH-1:0] b_val,
  input  logic [IDX_W-1:0] b_idx,
  input  logic             b_pres,
  output logic [WIDTH-1:0] val,
  output logic [IDX_W-1:0] idx,
  output logic             pres,
  output logic             mode,
  output logic             sgn
);

  logic [MAX_W-1:0] a_al;
  logic [MAX_W-1:0] b_al;
  logic             pick_a;
  logic [WIDTH-1:0] val_d;
  logic [IDX_W-1:0] idx_d;
  logic             pres_d;

  assign a_al   = MAX_W'(a_val) << (MAX_W - WIDTH);
  assign b_al   = MAX_W'(b_val) << (MAX_W - WIDTH);
  assign pick_a = minmax_sel(a_al, b_al, a_pres, b_pres, a_mode, a_sgn);

  always_comb begin
    val_d  = '0;
    idx_d  = '0;
    pres_d = 1'b0;
    if (a_pres || b_pres) begin
      pres_d = 1'b1;
      val_d  = pick_a ? a_val : b_val;
      idx_d  = pick_a ? a_idx : b_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val  <= '0;
      idx  <= '0;
      pres <= 1'b0;
      mode <= 1'b0;
      sgn  <= 1'b0;
    end else if (en) begin
      val  <= val_d;
      idx  <= idx_d;
      pres <= pres_d;
      mode <= a_mode;
      sgn  <= a_sgn;
    end
  end

endmodule

// File: rtl/minmax_tree_pipe.sv
// Pipelined min/max reduction over NUM_CH channels with masking, winner index and flow control.
module minmax_tree_pipe
  import minmax_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int IDX_W  = $clog2(NUM_CH),
  localparam int LEVELS = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_mask,
  input  logic                    in_mode,
  input  logic                    in_signed,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_none
);

  localparam int LEAVES = 1 << LEVELS;
  localparam int NODES  = 2 * LEAVES - 1;

  // Heap numbering: node 0 is the root, node i has children 2i+1 (left) and 2i+2.
  logic [WIDTH-1:0] n_val  [NODES];
  logic [IDX_W-1:0] n_idx  [NODES];
  logic             n_pres [NODES];
  logic             n_mode [NODES];
  logic             n_sgn  [NODES];

  logic              stall;
  logic              en;
  logic [LEVELS-1:0] vld_q;
  logic [LEVELS-1:0] vld_d;

  assign stall    = vld_q[0] && !out_ready;
  assign en       = !stall;
  assign in_ready = !stall;

  for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
    if (k < NUM_CH) begin : g_real
      assign n_val[LEAVES-1+k]  = in_data[k*WIDTH +: WIDTH];
      assign n_pres[LEAVES-1+k] = in_mask[k];
    end else begin : g_pad
      assign n_val[LEAVES-1+k]  = '0;
      assign n_pres[LEAVES-1+k] = 1'b0;
    end
    assign n_idx[LEAVES-1+k]  = IDX_W'(k);
    assign n_mode[LEAVES-1+k] = in_mode;
    assign n_sgn[LEAVES-1+k]  = in_signed;
  end

  for (genvar i = 0; i < LEAVES - 1; i++) begin : g_node
    minmax_node #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
    ) u_node (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .a_val  (n_val[2*i+1]),
      .a_idx  (n_idx[2*i+1]),
      .a_pres (n_pres[2*i+1]),
      .a_mode (n_mode[2*i+1]),
      .a_sgn  (n_sgn[2*i+1]),
      .b_val  (n_val[2*i+2]),
      .b_idx  (n_idx[2*i+2]),
      .b_pres (n_pres[2*i+2]),
      .val    (n_val[i]),
      .idx    (n_idx[i]),
      .pres   (n_pres[i]),
      .mode   (n_mode[i]),
      .sgn    (n_sgn[i])
    );
  end

  // vld_q[LEVELS-1] tracks the deepest stage, vld_q[0] the root.
  always_comb begin
    vld_d           = '0;
    vld_d[LEVELS-1] = in_valid;
    for (int l = 0; l < LEVELS - 1; l++) begin
      vld_d[l] = vld_q[l+1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q <= vld_d;
    end
  end

  assign out_valid = vld_q[0];
  assign out_data  = n_val[0];
  assign out_idx   = n_idx[0];
  assign out_none  = vld_q[0] && !n_pres[0];

endmodule

// File: tb/tb_minmax_tree_pipe.sv
// Directed bench for minmax_tree_pipe at NUM_CH=4 and NUM_CH=5.
module tb_minmax_tree_pipe;

  logic        clk = 1'b0;
  logic        rst;
  int          n_cmp = 0;
  int          n_err = 0;

  logic        in_valid4, in_ready4, in_mode4, in_signed4, out_valid4, out_ready4, out_none4;
  logic [31:0] in_data4;
  logic [3:0]  in_mask4;
  logic [7:0]  out_data4;
  logic [1:0]  out_idx4;

  logic        in_valid5, in_ready5, in_mode5, in_signed5, out_valid5, out_ready5, out_none5;
  logic [39:0] in_data5;
  logic [4:0]  in_mask5;
  logic [7:0]  out_data5;
  logic [2:0]  out_idx5;

  always #5 clk = ~clk;

  minmax_tree_pipe #(.WIDTH(8), .NUM_CH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_data   (in_data4),
    .in_mask   (in_mask4),
    .in_mode   (in_mode4),
    .in_signed (in_signed4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_data  (out_data4),
    .out_idx   (out_idx4),
    .out_none  (out_none4)
  );

  minmax_tree_pipe #(.WIDTH(8), .NUM_CH(5)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .in_data   (in_data5),
    .in_mask   (in_mask5),
    .in_mode   (in_mode5),
    .in_signed (in_signed5),
    .out_valid (out_valid5),
    .out_ready (out_ready5),
    .out_data  (out_data5),
    .out_idx   (out_idx5),
    .out_none  (out_none5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic [31:0] d, input logic [3:0] m, input logic md,
                        input logic sg);
    in_valid4  = 1'b1;
    in_data4   = d;
    in_mask4   = m;
    in_mode4   = md;
    in_signed4 = sg;
  endtask

  task automatic chk_out4(input string tag, input logic [7:0] d, input logic [1:0] ix,
                          input logic nn);
    chk({tag, "_valid"}, 32'(out_valid4), 32'd1);
    chk({tag, "_data"}, 32'(out_data4), 32'(d));
    chk({tag, "_idx"}, 32'(out_idx4), 32'(ix));
    chk({tag, "_none"}, 32'(out_none4), 32'(nn));
  endtask

  initial begin
    int          sent;
    int          recv;
    int          w;
    logic [31:0] d;
    logic        ok_stall;

    rst        = 1'b1;
    in_valid4  = 1'b0; in_data4 = '0; in_mask4 = '0; in_mode4 = 1'b0; in_signed4 = 1'b0;
    out_ready4 = 1'b1;
    in_valid5  = 1'b0; in_data5 = '0; in_mask5 = '0; in_mode5 = 1'b0; in_signed5 = 1'b0;
    out_ready5 = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid4), 32'd0);
    chk("rst_in_ready", 32'(in_ready4), 32'd1);
    step();
    step();
    chk("rst_out_data", 32'(out_data4), 32'd0);
    chk("rst_out_idx", 32'(out_idx4), 32'd0);
    chk("rst_out_none", 32'(out_none4), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(in_ready4), 32'd1);

    // Min then max of the same data back-to-back.
    drive4(32'h20301040, 4'hF, 1'b0, 1'b0);
    step();
    chk("lat_first", 32'(out_valid4), 32'd0);
    drive4(32'h20301040, 4'hF, 1'b1, 1'b0);
    step();
    chk_out4("min_u", 8'h10, 2'd1, 1'b0);
    in_valid4 = 1'b0;
    step();
    chk_out4("max_u", 8'h40, 2'd0, 1'b0);
    step();
    chk("drain_valid", 32'(out_valid4), 32'd0);

    // Signed versus unsigned max on {0x80,0x7F,0xFF,0x00}.
    drive4(32'h00FF7F80, 4'hF, 1'b1, 1'b1);
    step();
    drive4(32'h00FF7F80, 4'hF, 1'b1, 1'b0);
    step();
    chk_out4("max_s", 8'h7F, 2'd1, 1'b0);
    drive4(32'h22222222, 4'hF, 1'b0, 1'b0);
    step();
    chk_out4("max_u2", 8'hFF, 2'd2, 1'b0);
    drive4(32'h05020901, 4'b1010, 1'b0, 1'b0);
    step();
    chk_out4("tie_min", 8'h22, 2'd0, 1'b0);
    drive4(32'h11223344, 4'h0, 1'b1, 1'b1);
    step();
    chk_out4("mask_min", 8'h05, 2'd3, 1'b0);
    in_valid4 = 1'b0;
    step();
    chk_out4("mask_none", 8'h00, 2'd0, 1'b1);
    step();

    // Backpressure: six vectors, out_ready low for cycles 4..6.
    sent = 0;
    recv = 0;
    for (int c = 0; c < 20; c++) begin
      w = sent % 4;
      d = 32'h01010101;
      d[w*8 +: 8] = 8'(8'h50 + sent);
      in_valid4  = (sent < 6);
      in_data4   = d;
      in_mask4   = 4'hF;
      in_mode4   = 1'b1;
      in_signed4 = 1'b0;
      out_ready4 = !(c >= 4 && c < 7);
      #1;
      if (c == 4) chk("bp_in_ready_low", 32'(in_ready4), 32'd0);
      if (c == 7) chk("bp_in_ready_rise", 32'(in_ready4), 32'd1);
      if (c >= 4 && c < 7) begin
        ok_stall = out_valid4 && (out_data4 == 8'(8'h50 + recv)) && (out_idx4 == 2'(recv % 4));
        chk($sformatf("bp_hold_c%0d", c), 32'(ok_stall), 32'd1);
      end
      if (out_valid4 && out_ready4) begin
        chk($sformatf("bp_data_%0d", recv), 32'(out_data4), 32'(8'h50 + recv));
        chk($sformatf("bp_idx_%0d", recv), 32'(out_idx4), 32'(recv % 4));
        recv++;
      end
      if (in_valid4 && in_ready4) sent++;
      step();
    end
    chk("bp_sent", 32'(sent), 32'd6);
    chk("bp_recv", 32'(recv), 32'd6);
    chk("bp_idle", 32'(out_valid4), 32'd0);
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;

    // Reset with two vectors in flight.
    drive4(32'h20301040, 4'hF, 1'b0, 1'b0);
    step();
    drive4(32'h20301040, 4'hF, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid4), 32'd0);
    chk("mid_rst_ready", 32'(in_ready4), 32'd1);
    step();
    rst       = 1'b0;
    in_valid4 = 1'b0;
    step();
    chk("post_rst_idle1", 32'(out_valid4), 32'd0);
    step();
    chk("post_rst_idle2", 32'(out_valid4), 32'd0);
    drive4(32'h00FF7F80, 4'hF, 1'b0, 1'b0);
    step();
    in_valid4 = 1'b0;
    chk("post_rst_lat1", 32'(out_valid4), 32'd0);
    step();
    chk_out4("post_rst_min", 8'h00, 2'd3, 1'b0);

    // NUM_CH=5, winner on ch4, latency 3.
    in_valid5  = 1'b1;
    in_data5   = 40'h0350403020;
    in_mask5   = 5'h1F;
    in_mode5   = 1'b0;
    in_signed5 = 1'b0;
    step();
    in_valid5 = 1'b0;
    chk("ch5_lat1", 32'(out_valid5), 32'd0);
    step();
    chk("ch5_lat2", 32'(out_valid5), 32'd0);
    step();
    chk("ch5_valid", 32'(out_valid5), 32'd1);
    chk("ch5_data", 32'(out_data5), 32'h03);
    chk("ch5_idx", 32'(out_idx5), 32'd4);
    chk("ch5_none", 32'(out_none5), 32'd0);
    step();
    chk("ch5_drain", 32'(out_valid5), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
